operate_ctrl: RTL and testbench

//  Moore control FSM sequencing fetch/decode/execute for the LC-3 operate subset (ADD, AND, NOT, PAUSE).

---
 rtl/lc3_ctrl_pkg.sv | 43 ++++
 rtl/operate_ctrl.sv | 147 ++++++++++++++
 tb/tb_operate_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 operate-subset control FSM.
// Holds the state enum, opcode/ALU encodings and the decode-branch helper.
package lc3_ctrl_pkg;

   typedef enum logic [3:0] {
      StHalt      = 4'd0,
      StFetchMar  = 4'd1,
      StFetchMem  = 4'd2,
      StFetchIr   = 4'd3,
      StDecode    = 4'd4,
      StExecAdd   = 4'd5,
      StExecAnd   = 4'd6,
      StExecNot   = 4'd7,
      StPauseWait = 4'd8,
      StPauseRel  = 4'd9
   } state_t;

   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_AND   = 2'b01;
   localparam logic [1:0] ALU_NOT   = 2'b10;
   localparam logic [1:0] ALU_PASSA = 2'b11;

   localparam logic [1:0] PCMUX_INC = 2'b00;

   // Unimplemented opcodes fall back to a fresh fetch; the PC was already advanced.
   function automatic state_t decode_op(input logic [3:0] op);
      state_t st;
      case (op)
         OP_ADD:   st = StExecAdd;
         OP_AND:   st = StExecAnd;
         OP_NOT:   st = StExecNot;
         OP_PAUSE: st = StPauseWait;
         default:  st = StFetchMar;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/operate_ctrl.sv
// Moore control FSM sequencing fetch/decode/execute for the LC-3 operate subset.
// Outputs are a pure decode of the current state (plus ir bits); reset masks all strobes.
module operate_ctrl
   import lc3_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2,
   parameter int unsigned CNT_W    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        cont,
   input  logic [15:0] ir,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        ld_ir,
   output logic        ld_pc,
   output logic        ld_cc,
   output logic        ld_reg,
   output logic        gate_pc,
   output logic        gate_mdr,
   output logic        gate_alu,
   output logic [1:0]  pcmux,
   output logic        drmux,
   output logic        sr1mux,
   output logic        sr2mux,
   output logic [1:0]  aluk,
   output logic        mem_rd,
   output logic [3:0]  state_dbg
);

   state_t             state_q, state_d;
   logic   [CNT_W-1:0] cnt_q, cnt_d;
   logic               cnt_last;

   // Only the opcode and the immediate-select bit steer this controller.
   logic unused_ir;
   assign unused_ir = ^{ir[11:6], ir[4:0]};

   assign cnt_last = (cnt_q == CNT_W'(MEM_WAIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StHalt;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter is zero everywhere except while counting memory wait cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StHalt: begin
            if (run) state_d = StFetchMar;
         end
         StFetchMar: state_d = StFetchMem;
         StFetchMem: begin
            if (cnt_last) state_d = StFetchIr;
            else          cnt_d   = cnt_q + CNT_W'(1);
         end
         StFetchIr:  state_d = StDecode;
         StDecode:   state_d = decode_op(ir[15:12]);
         StExecAdd,
         StExecAnd,
         StExecNot:  state_d = StFetchMar;
         StPauseWait: begin
            if (cont) state_d = StPauseRel;
         end
         StPauseRel: begin
            if (!cont) state_d = StFetchMar;
         end
         default:    state_d = StHalt;
      endcase
   end

   always_comb begin
      ld_mar   = 1'b0;
      ld_mdr   = 1'b0;
      ld_ir    = 1'b0;
      ld_pc    = 1'b0;
      ld_cc    = 1'b0;
      ld_reg   = 1'b0;
      gate_pc  = 1'b0;
      gate_mdr = 1'b0;
      gate_alu = 1'b0;
      pcmux    = PCMUX_INC;
      drmux    = 1'b0;
      sr1mux   = 1'b0;
      sr2mux   = 1'b0;
      aluk     = ALU_ADD;
      mem_rd   = 1'b0;
      unique case (state_q)
         StFetchMar: begin
            gate_pc = 1'b1;
            ld_mar  = 1'b1;
            ld_pc   = 1'b1;
         end
         StFetchMem: begin
            mem_rd = 1'b1;
            ld_mdr = cnt_last;
         end
         StFetchIr: begin
            gate_mdr = 1'b1;
            ld_ir    = 1'b1;
         end
         StExecAdd, StExecAnd: begin
            gate_alu = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
            sr1mux   = 1'b1;
            sr2mux   = ir[5];
            aluk     = (state_q == StExecAnd) ? ALU_AND : ALU_ADD;
         end
         StExecNot: begin
            gate_alu = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
            sr1mux   = 1'b1;
            aluk     = ALU_NOT;
         end
         default: ;
      endcase
      // A reset arriving mid-execute must not let the register write through.
      if (reset) begin
         ld_mar   = 1'b0;
         ld_mdr   = 1'b0;
         ld_ir    = 1'b0;
         ld_pc    = 1'b0;
         ld_cc    = 1'b0;
         ld_reg   = 1'b0;
         gate_pc  = 1'b0;
         gate_mdr = 1'b0;
         gate_alu = 1'b0;
         sr1mux   = 1'b0;
         sr2mux   = 1'b0;
         aluk     = ALU_ADD;
         mem_rd   = 1'b0;
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_operate_ctrl.sv
// Directed bench for operate_ctrl: fetch timing, operate decode, pause handshake,
// unimplemented opcodes, reset during execute and back-to-back instructions.
module tb_operate_ctrl;

   logic        clk = 1'b0;
   logic        reset, run, cont;
   logic [15:0] ir;
   logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg;
   logic        gate_pc, gate_mdr, gate_alu;
   logic [1:0]  pcmux, aluk;
   logic        drmux, sr1mux, sr2mux, mem_rd;
   logic [3:0]  state_dbg;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   operate_ctrl #(.MEM_WAIT(2), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .run(run), .cont(cont), .ir(ir),
      .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc),
      .ld_cc(ld_cc), .ld_reg(ld_reg), .gate_pc(gate_pc), .gate_mdr(gate_mdr),
      .gate_alu(gate_alu), .pcmux(pcmux), .drmux(drmux), .sr1mux(sr1mux),
      .sr2mux(sr2mux), .aluk(aluk), .mem_rd(mem_rd), .state_dbg(state_dbg)
   );

   function automatic logic [17:0] all_outs();
      return {ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg, gate_pc, gate_mdr, gate_alu,
              pcmux, drmux, sr1mux, sr2mux, aluk, mem_rd};
   endfunction

   // Advance one cycle and sample 1 time unit after the edge; bus gates checked every cycle.
   task automatic step();
      @(posedge clk);
      #1;
      vectors++;
      if (!$onehot0({gate_pc, gate_mdr, gate_alu})) begin
         errors++;
         $display("FAIL gate_onehot: gates=%b required one-hot-or-zero",
                  {gate_pc, gate_mdr, gate_alu});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      cont  = 1'b0;
      repeat (3) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ir    = 16'h0000;
      reset = 1'b1;
      run   = 1'b0;
      cont  = 1'b0;
      repeat (3) step();
      vectors++;
      if (state_dbg !== 4'd0 || all_outs() !== 18'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d outs=%h required 0/0", state_dbg, all_outs());
      end
      reset = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step();
         vectors++;
         if (state_dbg !== 4'd0 || all_outs() !== 18'd0) begin
            errors++;
            $display("FAIL halt_idle c%0d: state=%0d outs=%h required 0/0",
                     c, state_dbg, all_outs());
         end
      end
   endtask

   task automatic test_add();
      logic [3:0] exp_st [1:6] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5};
      int pulses = 0;
      int pulse_at = 0;
      do_reset();
      ir  = 16'h1283;
      run = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         run = 1'b0;
         if (ld_reg) begin
            pulses++;
            pulse_at = c;
         end
         vectors++;
         if (state_dbg !== exp_st[c]) begin
            errors++;
            $display("FAIL add_state c%0d: got %0d required %0d", c, state_dbg, exp_st[c]);
         end
         if (c == 1) begin
            vectors++;
            if ({gate_pc, ld_mar, ld_pc, pcmux} !== 5'b11100) begin
               errors++;
               $display("FAIL fetch_mar: got %b required 11100", {gate_pc, ld_mar, ld_pc, pcmux});
            end
         end
         if (c == 2 || c == 3) begin
            vectors++;
            if ({mem_rd, ld_mdr} !== ((c == 3) ? 2'b11 : 2'b10)) begin
               errors++;
               $display("FAIL fetch_mem c%0d: mem_rd/ld_mdr=%b required %b",
                        c, {mem_rd, ld_mdr}, (c == 3) ? 2'b11 : 2'b10);
            end
         end
         if (c == 4) begin
            vectors++;
            if ({gate_mdr, ld_ir} !== 2'b11) begin
               errors++;
               $display("FAIL fetch_ir: got %b required 11", {gate_mdr, ld_ir});
            end
         end
         if (c == 5) begin
            vectors++;
            if (all_outs() !== 18'd0) begin
               errors++;
               $display("FAIL decode_quiet: outs=%h required 0", all_outs());
            end
         end
         if (c == 6) begin
            vectors++;
            if ({gate_alu, ld_reg, ld_cc, drmux, sr1mux, sr2mux, aluk} !== 8'b11101000) begin
               errors++;
               $display("FAIL exec_add: got %b required 11101000",
                        {gate_alu, ld_reg, ld_cc, drmux, sr1mux, sr2mux, aluk});
            end
         end
      end
      vectors++;
      if (pulses !== 1 || pulse_at !== 6) begin
         errors++;
         $display("FAIL add_ld_reg: pulses=%0d at cycle %0d required 1 at 6", pulses, pulse_at);
      end
   endtask

   task automatic test_and();
      do_reset();
      ir  = 16'h5262;
      run = 1'b1;
      step();
      run = 1'b0;
      repeat (5) step();
      vectors++;
      if ({state_dbg, ld_reg, sr2mux, aluk} !== {4'd6, 1'b1, 1'b1, 2'b01}) begin
         errors++;
         $display("FAIL exec_and: state/ld_reg/sr2mux/aluk=%b required %b",
                  {state_dbg, ld_reg, sr2mux, aluk}, {4'd6, 1'b1, 1'b1, 2'b01});
      end
   endtask

   task automatic test_not();
      do_reset();
      ir  = 16'h927F;
      run = 1'b1;
      step();
      run = 1'b0;
      repeat (5) step();
      vectors++;
      if ({state_dbg, ld_reg, ld_cc, sr2mux, aluk, sr1mux} !==
          {4'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1}) begin
         errors++;
         $display("FAIL exec_not: got %b required %b",
                  {state_dbg, ld_reg, ld_cc, sr2mux, aluk, sr1mux},
                  {4'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1});
      end
   endtask

   task automatic test_nop();
      int writes = 0;
      do_reset();
      ir  = 16'hF025;
      run = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         run = 1'b0;
         if (ld_reg || ld_cc) writes++;
      end
      vectors++;
      if (state_dbg !== 4'd1 || writes !== 0) begin
         errors++;
         $display("FAIL nop: state=%0d writes=%0d required 1/0", state_dbg, writes);
      end
   endtask

   task automatic test_pause();
      int busy = 0;
      int mar_pulses = 0;
      do_reset();
      ir  = 16'hD000;
      run = 1'b1;
      step();
      run = 1'b0;
      repeat (5) step();
      for (int c = 0; c < 10; c++) begin
         step();
         if (all_outs() !== 18'd0) busy++;
      end
      vectors++;
      if (state_dbg !== 4'd8 || busy !== 0) begin
         errors++;
         $display("FAIL pause_park: state=%0d active=%0d required 8/0", state_dbg, busy);
      end
      cont = 1'b1;
      repeat (3) step();
      vectors++;
      if (state_dbg !== 4'd9 || ld_mar !== 1'b0) begin
         errors++;
         $display("FAIL pause_rel: state=%0d ld_mar=%b required 9/0", state_dbg, ld_mar);
      end
      cont = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (ld_mar) mar_pulses++;
      end
      vectors++;
      if (mar_pulses !== 1 || state_dbg !== 4'd8) begin
         errors++;
         $display("FAIL pause_step: ld_mar pulses=%0d state=%0d required 1/8",
                  mar_pulses, state_dbg);
      end
   endtask

   task automatic test_reset_exec();
      do_reset();
      ir  = 16'h1283;
      run = 1'b1;
      step();
      run = 1'b0;
      repeat (5) step();
      vectors++;
      if (state_dbg !== 4'd5 || ld_reg !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_exec: state=%0d ld_reg=%b required 5/1", state_dbg, ld_reg);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (ld_reg !== 1'b0) begin
         errors++;
         $display("FAIL reset_exec_ld_reg: got %b required 0", ld_reg);
      end
      step();
      vectors++;
      if (state_dbg !== 4'd0 || ld_reg !== 1'b0) begin
         errors++;
         $display("FAIL reset_exec_next: state=%0d ld_reg=%b required 0/0", state_dbg, ld_reg);
      end
      reset = 1'b0;
      step();
      vectors++;
      if (state_dbg !== 4'd0) begin
         errors++;
         $display("FAIL reset_exec_halt: state=%0d required 0", state_dbg);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int first_at = 0;
      int last_at = 0;
      do_reset();
      ir  = 16'h1283;
      run = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         step();
         if (ld_reg) begin
            pulses++;
            if (first_at == 0) first_at = c;
            last_at = c;
         end
      end
      run = 1'b0;
      vectors++;
      if (pulses !== 2 || first_at !== 6 || last_at !== 12) begin
         errors++;
         $display("FAIL back_to_back: pulses=%0d at %0d,%0d required 2 at 6,12",
                  pulses, first_at, last_at);
      end
   endtask

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      cont  = 1'b0;
      ir    = 16'h0000;
      test_reset();
      test_add();
      test_and();
      test_not();
      test_nop();
      test_pause();
      test_reset_exec();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
